lcd_ctrl: RTL and testbench

HD44780 character-LCD timing engine that drives the DE2 LCD pins (LCD_DATA, LCD_RW, LCD_RS, LCD_EN, LCD_ON) on behalf of the pipelined CPU's LCD IO path. Accepts one byte at a time from the IO store path through a valid/ready handshake, runs the power-up init sequence on its own, and generates setup, enable-pulse, hold and execution-wait timing from CLOCK_50. With this block in place, software no longer toggles LCD_EN by hand through io_lcd.

---
 rtl/lcd_ctrl_if.sv | 16 +
 rtl/lcd_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ctrl_if
// Brief    : Byte request channel from the CPU IO store path to lcd_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;

  modport master (output req_valid, output req_rs, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rs, input req_data, output req_ready);
endinterface
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ctrl
// Brief    : HD44780 timing engine with automatic power-up init; optional
//            request FIFO enabled by defining LCD_FIFO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_ctrl #(
  parameter int POWERUP_CYC    = 2000000,
  parameter int SETUP_CYC      = 4,
  parameter int EN_PULSE_CYC   = 24,
  parameter int HOLD_CYC       = 2,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  lcd_ctrl_if.slave  req,
  output logic       init_done_o,
  output logic       busy_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o
);

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int c_max_cyc = f_max(f_max(f_max(POWERUP_CYC, CLEAR_WAIT_CYC), f_max(CMD_WAIT_CYC, SETUP_CYC)),
                                   f_max(EN_PULSE_CYC, HOLD_CYC));
  localparam int c_cw      = $clog2(c_max_cyc + 1);
  localparam logic [c_cw-1:0] c_pwrup_m1 = c_cw'(POWERUP_CYC - 1);
  localparam logic [c_cw-1:0] c_setup_m1 = c_cw'(SETUP_CYC - 1);
  localparam logic [c_cw-1:0] c_pulse_m1 = c_cw'(EN_PULSE_CYC - 1);
  localparam logic [c_cw-1:0] c_hold_m1  = c_cw'(HOLD_CYC - 1);
  localparam logic [c_cw-1:0] c_cmd_m1   = c_cw'(CMD_WAIT_CYC - 1);
  localparam logic [c_cw-1:0] c_clear_m1 = c_cw'(CLEAR_WAIT_CYC - 1);
  localparam bit c_params_ok = (POWERUP_CYC > 0) && (SETUP_CYC > 0) && (EN_PULSE_CYC > 0) &&
                               (HOLD_CYC > 0) && (CMD_WAIT_CYC > 0) && (CLEAR_WAIT_CYC > 0) &&
                               (FIFO_DEPTH > 0);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_IDLE  = 3'd5
  } state_t;

  function automatic logic [7:0] f_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: return 8'h38;
      3'd2:       return 8'h0C;
      3'd3:       return 8'h01;
      default:    return 8'h06;
    endcase
  endfunction

  state_t          r_state;
  logic [c_cw-1:0] r_cnt;
  logic [c_cw-1:0] w_dur_m1;
  logic            w_last;
  logic [2:0]      r_idx;
  logic            r_rs;
  logic [7:0]      r_data;
  logic            r_en;
  logic            r_on;
  logic            r_init_done;
  logic            w_ready;
  logic            w_take;
  logic            w_take_rs;
  logic [7:0]      w_take_data;

`ifdef LCD_FIFO_EN
  localparam int c_pw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_nw = $clog2(FIFO_DEPTH + 1);

  logic [8:0]      r_fifo [FIFO_DEPTH];
  logic [c_pw-1:0] r_wptr;
  logic [c_pw-1:0] r_rptr;
  logic [c_nw-1:0] r_count;
  logic            w_empty;
  logic            w_full;
  logic            w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_nw'(FIFO_DEPTH));
  assign w_take  = (r_state == S_IDLE) && r_init_done && !w_empty;
  assign {w_take_rs, w_take_data} = r_fifo[r_rptr];
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_ready = !w_full || w_take;
  assign w_push  = req.req_valid && req.req_ready;
  assign busy_o  = !rst_i && ((r_state != S_IDLE) || !w_empty);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= {req.req_rs, req.req_data};
        r_wptr         <= (r_wptr == c_pw'(FIFO_DEPTH - 1)) ? '0 : r_wptr + c_pw'(1);
      end
      if (w_take) begin
        r_rptr <= (r_rptr == c_pw'(FIFO_DEPTH - 1)) ? '0 : r_rptr + c_pw'(1);
      end
      case ({w_push, w_take})
        2'b10:   r_count <= r_count + c_nw'(1);
        2'b01:   r_count <= r_count - c_nw'(1);
        default: r_count <= r_count;
      endcase
    end
  end
`else
  assign w_ready     = (r_state == S_IDLE);
  assign w_take      = w_ready && req.req_valid;
  assign w_take_rs   = req.req_rs;
  assign w_take_data = req.req_data;
  assign busy_o      = !rst_i && !w_ready;
`endif

  assign req.req_ready = w_ready && !rst_i;

  // Clear and return-home (0x00-0x03 as commands) need the long execution wait.
  always_comb begin
    w_dur_m1 = '0;
    case (r_state)
      S_PWRUP: w_dur_m1 = c_pwrup_m1;
      S_SETUP: w_dur_m1 = c_setup_m1;
      S_PULSE: w_dur_m1 = c_pulse_m1;
      S_HOLD:  w_dur_m1 = c_hold_m1;
      S_WAIT:  w_dur_m1 = (!r_rs && (r_data[7:2] == 6'd0)) ? c_clear_m1 : c_cmd_m1;
      default: w_dur_m1 = '0;
    endcase
  end

  assign w_last = (r_cnt == w_dur_m1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_PWRUP;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_en        <= 1'b0;
      r_on        <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_on <= 1'b1;
      if (r_state != S_IDLE) begin
        r_cnt <= w_last ? '0 : r_cnt + c_cw'(1);
      end
      case (r_state)
        S_PWRUP: if (w_last) begin
          r_state <= S_SETUP;
          r_rs    <= 1'b0;
          r_data  <= f_rom(3'd0);
        end
        S_SETUP: if (w_last) begin
          r_state <= S_PULSE;
          r_en    <= 1'b1;
        end
        S_PULSE: if (w_last) begin
          r_state <= S_HOLD;
          r_en    <= 1'b0;
        end
        S_HOLD: if (w_last) begin
          r_state <= S_WAIT;
        end
        S_WAIT: if (w_last) begin
          if (!r_init_done && (r_idx != 3'd4)) begin
            r_state <= S_SETUP;
            r_idx   <= r_idx + 3'd1;
            r_data  <= f_rom(r_idx + 3'd1);
          end else begin
            r_state     <= S_IDLE;
            r_init_done <= 1'b1;
          end
        end
        S_IDLE: if (w_take) begin
          r_state <= S_SETUP;
          r_rs    <= w_take_rs;
          r_data  <= w_take_data;
        end
        default: r_state <= S_PWRUP;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (c_params_ok) else $error("lcd_ctrl: timing parameters must be non-zero");
    end
  end

  assign init_done_o = r_init_done;
  assign lcd_data_o  = r_data;
  assign lcd_rs_o    = r_rs;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = r_en;
  assign lcd_on_o    = r_on;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_ctrl
// Brief    : Scoreboard bench for lcd_ctrl (default build, no FIFO).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_ctrl;

  localparam int c_setup = 2;
  localparam int c_pulse = 3;
  localparam int c_hold  = 1;
  localparam int c_cmd   = 10;
  localparam int c_clear = 40;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    int         start;
    int         width;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done;
  logic       busy;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  pulse_t exp_q[$];

  lcd_ctrl_if bus ();

  lcd_ctrl #(
    .POWERUP_CYC   (100),
    .SETUP_CYC     (c_setup),
    .EN_PULSE_CYC  (c_pulse),
    .HOLD_CYC      (c_hold),
    .CMD_WAIT_CYC  (c_cmd),
    .CLEAR_WAIT_CYC(c_clear),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req        (bus.slave),
    .init_done_o(init_done),
    .busy_o     (busy),
    .lcd_data_o (lcd_data),
    .lcd_rs_o   (lcd_rs),
    .lcd_rw_o   (lcd_rw),
    .lcd_en_o   (lcd_en),
    .lcd_on_o   (lcd_on)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the first cycle after the last reset edge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every EN pulse is matched against the next scoreboard entry.
  logic       mon_en = 1'b0;
  logic       mon_rs;
  logic [7:0] mon_data;
  int         mon_start;
  int         mon_w;

  always @(negedge clk) begin
    pulse_t e;
    if (lcd_en && !mon_en) begin
      mon_start = cyc;
      mon_w     = 1;
      mon_rs    = lcd_rs;
      mon_data  = lcd_data;
      check("rw_during_pulse", {31'd0, lcd_rw}, 32'd0);
    end else if (lcd_en) begin
      mon_w++;
    end else if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got data %0h rs %0d at cycle %0d, expected no pulse",
                 mon_data, mon_rs, mon_start);
      end else begin
        e = exp_q.pop_front();
        check("pulse_rs",    {31'd0, mon_rs},   {31'd0, e.rs});
        check("pulse_data",  {24'd0, mon_data}, {24'd0, e.data});
        check("pulse_start", mon_start,         e.start);
        check("pulse_width", mon_w,             e.width);
      end
    end
    mon_en = lcd_en;
  end

  task automatic push_init();
    exp_q.push_back('{1'b0, 8'h38, 102, c_pulse});
    exp_q.push_back('{1'b0, 8'h38, 118, c_pulse});
    exp_q.push_back('{1'b0, 8'h0C, 134, c_pulse});
    exp_q.push_back('{1'b0, 8'h01, 150, c_pulse});
    exp_q.push_back('{1'b0, 8'h06, 196, c_pulse});
  endtask

  task automatic check_reset_outputs();
    check("rst_data",      {24'd0, lcd_data},  32'd0);
    check("rst_rs",        {31'd0, lcd_rs},    32'd0);
    check("rst_rw",        {31'd0, lcd_rw},    32'd0);
    check("rst_en",        {31'd0, lcd_en},    32'd0);
    check("rst_on",        {31'd0, lcd_on},    32'd0);
    check("rst_ready",     {31'd0, bus.req_ready}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
  endtask

  task automatic wait_ready(output int at);
    int n;
    n = 0;
    while (!bus.req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    at = bus.req_ready ? cyc : -1;
  endtask

  // Issue one request at a negedge; the expected pulse starts 3 cycles after accept.
  task automatic send(input logic rs, input logic [7:0] d, input int w_exp);
    int t;
    int r;
    wait_ready(t);
    exp_q.push_back('{rs, d, t + 1 + c_setup, c_pulse});
    bus.req_valid = 1'b1;
    bus.req_rs    = rs;
    bus.req_data  = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("accept_rs",    {31'd0, lcd_rs},        {31'd0, rs});
    check("accept_data",  {24'd0, lcd_data},      {24'd0, d});
    check("accept_ready", {31'd0, bus.req_ready}, 32'd0);
    check("accept_busy",  {31'd0, busy},          32'd1);
    wait_ready(r);
    check("ready_return", r - t, 1 + c_setup + c_pulse + c_hold + w_exp);
  endtask

  initial begin
    int n;
    int t;
    int r;
    bus.req_valid = 1'b0;
    bus.req_rs    = 1'b0;
    bus.req_data  = 8'h00;

    // Power-up init sequence
    repeat (3) @(negedge clk);
    check_reset_outputs();
    push_init();
    rst = 1'b0;
    n = 0;
    while (!init_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("init_done_cycle", cyc, 210);
    check("init_ready",      {31'd0, bus.req_ready}, 32'd1);
    check("init_busy",       {31'd0, busy},          32'd0);
    check("init_lcd_on",     {31'd0, lcd_on},        32'd1);

    // Data byte, then command wait-length boundaries
    send(1'b1, 8'h41, c_cmd);
    send(1'b0, 8'h01, c_clear);
    send(1'b0, 8'h80, c_cmd);
    send(1'b0, 8'h03, c_clear);
    send(1'b0, 8'h04, c_cmd);
    send(1'b1, 8'h01, c_cmd);
    check("idle_data_kept", {24'd0, lcd_data}, 32'h01);

    // Reset during the second cycle of an EN pulse
    wait_ready(t);
    exp_q.push_back('{1'b1, 8'h42, t + 3, 2});
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b1;
    bus.req_data  = 8'h42;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pulse_cycle1_en", {31'd0, lcd_en}, 32'd1);
    @(negedge clk);
    check("pulse_cycle2_en", {31'd0, lcd_en}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("en_after_reset", {31'd0, lcd_en}, 32'd0);
    check_reset_outputs();
    @(negedge clk);
    check_reset_outputs();

    // Request held valid through init must wait for cycle 210
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b1;
    bus.req_data  = 8'h55;
    push_init();
    exp_q.push_back('{1'b1, 8'h55, 213, c_pulse});
    rst = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("held_accept_cycle", cyc, 210);
    check("held_init_done", {31'd0, init_done}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("held_rs",    {31'd0, lcd_rs},        32'd1);
    check("held_data",  {24'd0, lcd_data},      32'h55);
    check("held_ready", {31'd0, bus.req_ready}, 32'd0);
    wait_ready(r);
    check("held_ready_return", r, 227);

    repeat (5) @(negedge clk);
    check("pending_pulses", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
